// File: rtl/event_sync_pkg.sv
// Shared types and helpers for the event synchronizer / arbiter.
// Holds the round-robin find-first search and the largest supported line count.
package event_sync_pkg;

  localparam int unsigned MaxNumIn = 32;
  localparam int unsigned MaxIdxW  = 5;

  // Result of a round-robin search: found flag plus winning index.
  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_grant_t;

  // First set bit of req at or above ptr, wrapping at num (only num lines are live).
  function automatic rr_grant_t rr_find_first(input logic [MaxNumIn-1:0] req,
                                              input logic [MaxIdxW-1:0]  ptr,
                                              input int unsigned         num);
    rr_grant_t   g;
    int unsigned pos;
    g   = '0;
    pos = 0;
    for (int unsigned k = 0; k < MaxNumIn; k++) begin
      if (k < num) begin
        pos = 32'(ptr) + k;
        if (pos >= num) pos = pos - num;
        if (!g.found && req[pos[MaxIdxW-1:0]]) begin
          g.found = 1'b1;
          g.idx   = pos[MaxIdxW-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/event_sync_arb_sync.sv
// Multi-flop synchronizer cell for one asynchronous level signal.
// Ports: clk_i clock, rst_ni async active-low reset, d_i async input,
//        q_o synchronized output (STAGES flops after d_i).
module event_sync_arb_sync #(
  parameter int unsigned STAGES     = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift chain; d_i enters at bit 0, output taken from the last stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= {STAGES{ResetValue}};
    else         ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/event_sync_arb.sv
// Synchronizes NumIn asynchronous event lines, captures rising edges as
// pending flags and presents them one at a time, round-robin, through a
// single valid/ready output register.
// Ports: clk_i clock; rst_i async active-high reset; evt_i async event levels;
//        evt_valid_o / evt_idx_o presented event; evt_ready_i consumer accept;
//        pending_o captured-not-presented flags; overflow_o sticky lost-event
//        flags; clr_ovf_i synchronous overflow clear.
module event_sync_arb
  import event_sync_pkg::*;
#(
  parameter  int unsigned NumIn      = 4,
  parameter  int unsigned SyncStages = 2,
  localparam int unsigned IdxW       = $clog2(NumIn)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumIn-1:0] evt_i,
  output logic             evt_valid_o,
  output logic [IdxW-1:0]  evt_idx_o,
  input  logic             evt_ready_i,
  output logic [NumIn-1:0] pending_o,
  output logic [NumIn-1:0] overflow_o,
  input  logic             clr_ovf_i
);

  logic             rst_n;
  logic [NumIn-1:0] evt_sync;
  logic [NumIn-1:0] evt_prev_q;
  logic [NumIn-1:0] rise;

  logic             valid_q, valid_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [NumIn-1:0] pending_q, pending_d;
  logic [NumIn-1:0] ovf_q, ovf_d;

  logic             load;
  rr_grant_t        grant;
  logic [NumIn-1:0] grant_mask;
  logic [NumIn-1:0] ovf_new;

  assign rst_n = ~rst_i;

  // One synchronizer per line.
  for (genvar i = 0; i < NumIn; i++) begin : g_sync
    event_sync_arb_sync #(
      .STAGES     (SyncStages),
      .ResetValue (1'b0)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_n),
      .d_i    (evt_i[i]),
      .q_o    (evt_sync[i])
    );
  end

  // Previous synchronized value for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) evt_prev_q <= '0;
    else       evt_prev_q <= evt_sync;
  end

  assign rise = evt_sync & ~evt_prev_q;

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      idx_q     <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Output load, round-robin grant, pending and overflow update.
  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    grant_mask = '0;

    load  = !valid_q || evt_ready_i;
    grant = rr_find_first(MaxNumIn'(pending_q), MaxIdxW'(rr_q), NumIn);

    if (load) begin
      valid_d = grant.found;
      if (grant.found) begin
        grant_mask = NumIn'(MaxNumIn'(1) << grant.idx);
        idx_d      = IdxW'(grant.idx);
        rr_d       = (32'(grant.idx) == NumIn - 1) ? '0 : IdxW'(32'(grant.idx) + 32'd1);
      end
    end

    // A rise on a line being granted this cycle re-arms it rather than overflowing.
    pending_d = (pending_q & ~grant_mask) | rise;
    ovf_new   = rise & pending_q & ~grant_mask;
    ovf_d     = (clr_ovf_i ? '0 : ovf_q) | ovf_new;
  end

  assign evt_valid_o = valid_q;
  assign evt_idx_o   = idx_q;
  assign pending_o   = pending_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_event_sync_arb.sv
// Directed self-checking bench for event_sync_arb (NumIn=4, SyncStages=2).
module tb_event_sync_arb;

  logic       clk;
  logic       rst;
  logic [3:0] evt;
  logic       valid;
  logic [1:0] idx;
  logic       ready;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       clr_ovf;

  int n_checks;
  int n_fail;

  event_sync_arb #(
    .NumIn      (4),
    .SyncStages (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (evt),
    .evt_valid_o (valid),
    .evt_idx_o   (idx),
    .evt_ready_i (ready),
    .pending_o   (pending),
    .overflow_o  (overflow),
    .clr_ovf_i   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns before driving/sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    evt     = '0;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    rst     = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    evt      = '0;
    ready    = 1'b0;
    clr_ovf  = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single pulse on line 2: valid exactly after edge 4, for one cycle
    do_reset();
    ready = 1'b1;
    evt   = 4'b0100;
    tick(3);
    check("pulse_not_yet", 32'(valid), 32'd0);
    check("pulse_pending", 32'(pending), 32'h4);
    tick(1);
    check("pulse_valid", 32'(valid), 32'd1);
    check("pulse_idx", 32'(idx), 32'd2);
    check("pulse_pend_clr", 32'(pending), 32'd0);
    tick(1);
    check("pulse_one_cycle", 32'(valid), 32'd0);

    // Round-robin batch {0,1,3} then {0,3}
    do_reset();
    ready = 1'b1;
    evt   = 4'b1011;
    tick(3);
    check("rr_pending", 32'(pending), 32'hb);
    tick(1);
    check("rr_a_valid", 32'(valid), 32'd1);
    check("rr_a_idx", 32'(idx), 32'd0);
    check("rr_a_pending", 32'(pending), 32'ha);
    tick(1);
    check("rr_b_idx", 32'(idx), 32'd1);
    tick(1);
    check("rr_c_valid", 32'(valid), 32'd1);
    check("rr_c_idx", 32'(idx), 32'd3);
    check("rr_c_pending", 32'(pending), 32'd0);
    tick(1);
    check("rr_drained", 32'(valid), 32'd0);
    evt = 4'b0000;
    tick(4);
    evt = 4'b1001;
    tick(4);
    check("rr2_a_valid", 32'(valid), 32'd1);
    check("rr2_a_idx", 32'(idx), 32'd0);
    tick(1);
    check("rr2_b_idx", 32'(idx), 32'd3);
    tick(1);
    check("rr2_drained", 32'(valid), 32'd0);

    // Backpressure: idx 1 held stable, re-rise of line 1 goes to pending only
    do_reset();
    ready = 1'b0;
    evt   = 4'b0010;
    tick(4);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_idx", 32'(idx), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) evt = 4'b0000;
      if (i == 4) evt = 4'b0010;
      tick(1);
      check("bp_hold_valid", 32'(valid), 32'd1);
      check("bp_hold_idx", 32'(idx), 32'd1);
    end
    check("bp_pending", 32'(pending), 32'h2);
    check("bp_no_ovf", 32'(overflow), 32'd0);
    ready = 1'b1;
    tick(1);
    check("bp_next_valid", 32'(valid), 32'd1);
    check("bp_next_idx", 32'(idx), 32'd1);
    check("bp_next_pend", 32'(pending), 32'd0);
    tick(1);
    check("bp_drained", 32'(valid), 32'd0);

    // Overflow: three rises on line 0 with the output stalled
    do_reset();
    ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      evt = 4'b0001;
      tick(3);
      evt = 4'b0000;
      tick(3);
      if (p == 1) begin
        check("ovf_p2_pending", 32'(pending), 32'h1);
        check("ovf_p2_none", 32'(overflow), 32'd0);
      end
    end
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_pending", 32'(pending), 32'h1);
    check("ovf_valid", 32'(valid), 32'd1);
    check("ovf_idx", 32'(idx), 32'd0);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-operation with valid=1 and pending=1010
    do_reset();
    ready = 1'b0;
    evt   = 4'b1011;
    tick(4);
    check("mid_valid", 32'(valid), 32'd1);
    check("mid_pending", 32'(pending), 32'ha);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_idx", 32'(idx), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    evt = 4'b0000;
    tick(2);
    rst   = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("post_rst_quiet", 32'({valid, pending}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
